// File: rtl/avalon_mem_if_arb2_if.sv
// avalon_mem_if_arb2_if
//   Avalon-MM command/response bundle shared by the arbiter's requester
//   and memory-side ports.
//   master modport: drives address/burstcount/writedata/byteenable/read/write,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image.
interface avalon_mem_if_arb2_if #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [DATA_WIDTH/8-1:0]    byteenable;
    logic                       read;
    logic                       write;
    logic                       waitrequest;
    logic [DATA_WIDTH-1:0]      readdata;
    logic                       readdatavalid;

    modport master (
        output address, burstcount, writedata, byteenable, read, write,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, writedata, byteenable, read, write,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_mem_if_arb2.sv
// avalon_mem_if_arb2
//   Shares one Avalon-MM memory port between two requesters. Commands are
//   granted round-robin at burst granularity; a write burst locks the port
//   to its owner until the last beat. Outstanding read bursts are recorded
//   ({id, burstcount}) in an order FIFO so returning beats are steered back
//   to the requester that issued them, registered with one cycle latency.
//   Ports:
//     clk, reset_n : single clock, asynchronous active-low reset
//     a0, a1       : requester ports (slave modport)
//     m            : memory-side port (master modport)
//     rd_err       : sticky, a return beat arrived with no read outstanding
//   Build option:
//     AVALON_MEM_ARB_STRICT_PRIO_EN - when defined, requester 0 wins every
//     tie in IDLE instead of alternating.
module avalon_mem_if_arb2 #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RD_FIFO_DEPTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    avalon_mem_if_arb2_if.slave  a0,
    avalon_mem_if_arb2_if.slave  a1,
    avalon_mem_if_arb2_if.master m,
    output logic                 rd_err
);
    localparam int FIFO_AW = $clog2(RD_FIFO_DEPTH);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WR_BURST = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [BURST_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [FIFO_AW:0]           wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]           rd_ptr_q, rd_ptr_d;
    logic [BURST_CNT_WIDTH:0]   fifo_mem_q [RD_FIFO_DEPTH];
    logic                       rd_err_q, rd_err_d;
    logic                       a0_rdv_q, a0_rdv_d, a1_rdv_q, a1_rdv_d;
    logic [DATA_WIDTH-1:0]      a0_rdata_q, a0_rdata_d, a1_rdata_q, a1_rdata_d;

    logic                       fifo_empty, fifo_full, rd_blocked;
    logic                       head_id, ret_valid, beat_last, pop, push;
    logic [BURST_CNT_WIDTH-1:0] head_bc;
    logic                       a0_act, a1_act, sel, grant, accept;
    logic                       sel_rd, sel_wr;
    logic [BURST_CNT_WIDTH-1:0] sel_bc, sel_bc_eff;

    // ---------------- order FIFO status / return path ----------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign head_id    = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]][BURST_CNT_WIDTH];
    assign head_bc    = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]][BURST_CNT_WIDTH-1:0];
    assign ret_valid  = m.readdatavalid && !fifo_empty;
    assign beat_last  = ({1'b0, beat_cnt_q} + (BURST_CNT_WIDTH+1)'(1)) == {1'b0, head_bc};
    assign pop        = ret_valid && beat_last;
    // A completing burst frees its slot in the same cycle, so a new read
    // can be accepted alongside the pop even when the FIFO is full.
    assign rd_blocked = fifo_full && !pop;

    // ---------------- arbitration / command path ----------------
    assign a0_act = a0.write || (a0.read && !rd_blocked);
    assign a1_act = a1.write || (a1.read && !rd_blocked);

    always_comb begin
        sel   = 1'b0;
        grant = 1'b0;
        if (!reset_n) begin
            grant = 1'b0;
        end else if (state_q == WR_BURST) begin
            sel   = owner_q;
            grant = owner_q ? a1.write : a0.write;
        end else if (a0_act && a1_act) begin
`ifdef AVALON_MEM_ARB_STRICT_PRIO_EN
            sel   = 1'b0;
`else
            sel   = ~last_q;
`endif
            grant = 1'b1;
        end else begin
            sel   = a1_act;
            grant = a0_act || a1_act;
        end
    end

    assign sel_rd     = sel ? a1.read       : a0.read;
    assign sel_wr     = sel ? a1.write      : a0.write;
    assign sel_bc     = sel ? a1.burstcount : a0.burstcount;
    assign sel_bc_eff = (sel_bc == '0) ? BURST_CNT_WIDTH'(1) : sel_bc;

    assign m.address    = sel ? a1.address    : a0.address;
    assign m.writedata  = sel ? a1.writedata  : a0.writedata;
    assign m.byteenable = sel ? a1.byteenable : a0.byteenable;
    assign m.burstcount = sel_bc;
    assign m.write      = grant && sel_wr;
    assign m.read       = grant && !sel_wr && sel_rd && (state_q == IDLE);

    assign accept = grant && !m.waitrequest;
    assign push   = accept && m.read;

    assign a0.waitrequest = !(grant && !sel) || m.waitrequest;
    assign a1.waitrequest = !(grant &&  sel) || m.waitrequest;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        beats_left_d = beats_left_q;
        if (accept) begin
            if (state_q == IDLE) begin
                if (sel_wr && (sel_bc_eff > BURST_CNT_WIDTH'(1))) begin
                    state_d      = WR_BURST;
                    owner_d      = sel;
                    beats_left_d = sel_bc_eff - BURST_CNT_WIDTH'(1);
                end else begin
                    last_d = sel;
                end
            end else begin
                beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
                if (beats_left_q == BURST_CNT_WIDTH'(1)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (FIFO_AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (FIFO_AW+1)'(pop);
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = '0;
        end else if (ret_valid) begin
            beat_cnt_d = beat_cnt_q + BURST_CNT_WIDTH'(1);
        end
        rd_err_d   = rd_err_q || (m.readdatavalid && fifo_empty);
        a0_rdv_d   = ret_valid && !head_id;
        a1_rdv_d   = ret_valid &&  head_id;
        a0_rdata_d = a0_rdv_d ? m.readdata : a0_rdata_q;
        a1_rdata_d = a1_rdv_d ? m.readdata : a1_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            beats_left_q <= '0;
            beat_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_err_q     <= 1'b0;
            a0_rdv_q     <= 1'b0;
            a1_rdv_q     <= 1'b0;
            a0_rdata_q   <= '0;
            a1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            beats_left_q <= beats_left_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_err_q     <= rd_err_d;
            a0_rdv_q     <= a0_rdv_d;
            a1_rdv_q     <= a1_rdv_d;
            a0_rdata_q   <= a0_rdata_d;
            a1_rdata_q   <= a1_rdata_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {sel, sel_bc_eff};
        end
    end

    assign a0.readdatavalid = a0_rdv_q;
    assign a1.readdatavalid = a1_rdv_q;
    assign a0.readdata      = a0_rdata_q;
    assign a1.readdata      = a1_rdata_q;
    assign rd_err           = rd_err_q;
endmodule

// File: tb/tb_avalon_mem_if_arb2.sv
module tb_avalon_mem_if_arb2;
    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int BW    = 7;
    localparam int DEPTH = 32;
    localparam logic [AW-1:0] A0_ADDR = 27'h100;
    localparam logic [AW-1:0] A1_ADDR = 27'h200;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rd_err;
    always #5 clk = ~clk;

    avalon_mem_if_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) a0_if ();
    avalon_mem_if_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) a1_if ();
    avalon_mem_if_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) m_if ();

    avalon_mem_if_arb2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .a0(a0_if), .a1(a1_if), .m(m_if), .rd_err(rd_err)
    );

    // exp_sel: 0/1 = requester expected on the memory port, 2 = nobody,
    // 3 = not a vector: drain all outstanding reads at this point.
    typedef struct {
        logic a0_rd; logic a0_wr; logic [BW-1:0] a0_bc;
        logic a1_rd; logic a1_wr; logic [BW-1:0] a1_bc;
        logic mwait; int exp_sel;
    } vec_t;
    typedef struct { logic id; logic [DW-1:0] data; int cyc; } ret_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    vec_t vecs[$];
    ret_t rq[$];
    logic oq_id[$];
    int   oq_bc[$];
    int   head_beats = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic a0r, input logic a0w, input int a0b,
                                input logic a1r, input logic a1w, input int a1b,
                                input logic mw, input int sel);
        vec_t v;
        v.a0_rd = a0r; v.a0_wr = a0w; v.a0_bc = BW'(a0b);
        v.a1_rd = a1r; v.a1_wr = a1w; v.a1_bc = BW'(a1b);
        v.mwait = mw;  v.exp_sel = sel;
        return v;
    endfunction

    task automatic set_req(input logic which, input logic rd, input logic wr,
                           input logic [BW-1:0] bc, input logic [DW-1:0] wd);
        if (!which) begin
            a0_if.read = rd; a0_if.write = wr; a0_if.burstcount = bc; a0_if.writedata = wd;
        end else begin
            a1_if.read = rd; a1_if.write = wr; a1_if.burstcount = bc; a1_if.writedata = wd;
        end
    endtask

    // Expected order of read bursts as issued by the bench.
    task automatic exp_read(input logic id, input logic [BW-1:0] bc);
        oq_id.push_back(id);
        oq_bc.push_back((bc == '0) ? 1 : int'(bc));
    endtask

    // Drive one return beat; the scoreboard expects it on the head
    // requester exactly one cycle later.
    task automatic drive_ret(input logic [DW-1:0] d);
        ret_t r;
        m_if.readdatavalid = 1'b1;
        m_if.readdata      = d;
        if (oq_id.size() > 0) begin
            r.id = oq_id[0]; r.data = d; r.cyc = cyc + 1;
            rq.push_back(r);
            head_beats++;
            if (head_beats == oq_bc[0]) begin
                void'(oq_id.pop_front());
                void'(oq_bc.pop_front());
                head_beats = 0;
            end
        end
    endtask

    task automatic settle();
        ret_t r;
        @(negedge clk);
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            check1("ret_a0_valid", a0_if.readdatavalid, r.id == 1'b0);
            check1("ret_a1_valid", a1_if.readdatavalid, r.id == 1'b1);
            checkw("ret_data", 64'(r.id ? a1_if.readdata : a0_if.readdata), 64'(r.data));
        end else begin
            check1("idle_a0_valid", a0_if.readdatavalid, 1'b0);
            check1("idle_a1_valid", a1_if.readdatavalid, 1'b0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        m_if.readdatavalid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic s_wr, s_rd;
        logic [BW-1:0] s_bc;
        logic [DW-1:0] wd0, wd1;
        wd0 = 32'hA000_0000 + DW'(idx);
        wd1 = 32'hB000_0000 + DW'(idx);
        set_req(1'b0, v.a0_rd, v.a0_wr, v.a0_bc, wd0);
        set_req(1'b1, v.a1_rd, v.a1_wr, v.a1_bc, wd1);
        m_if.waitrequest = v.mwait;
        settle();
        if (v.exp_sel == 2) begin
            check1($sformatf("v%0d_m_write", idx), m_if.write, 1'b0);
            check1($sformatf("v%0d_m_read", idx), m_if.read, 1'b0);
            check1($sformatf("v%0d_a0_wait", idx), a0_if.waitrequest, 1'b1);
            check1($sformatf("v%0d_a1_wait", idx), a1_if.waitrequest, 1'b1);
        end else begin
            s_wr = (v.exp_sel == 1) ? v.a1_wr : v.a0_wr;
            s_rd = (v.exp_sel == 1) ? v.a1_rd : v.a0_rd;
            s_bc = (v.exp_sel == 1) ? v.a1_bc : v.a0_bc;
            check1($sformatf("v%0d_m_write", idx), m_if.write, s_wr);
            check1($sformatf("v%0d_m_read", idx), m_if.read, !s_wr && s_rd);
            checkw($sformatf("v%0d_m_addr", idx), 64'(m_if.address),
                   64'((v.exp_sel == 1) ? A1_ADDR : A0_ADDR));
            checkw($sformatf("v%0d_m_bc", idx), 64'(m_if.burstcount), 64'(s_bc));
            if (s_wr)
                checkw($sformatf("v%0d_m_wdata", idx), 64'(m_if.writedata),
                       64'((v.exp_sel == 1) ? wd1 : wd0));
            check1($sformatf("v%0d_a0_wait", idx), a0_if.waitrequest, !(v.exp_sel == 0 && !v.mwait));
            check1($sformatf("v%0d_a1_wait", idx), a1_if.waitrequest, !(v.exp_sel == 1 && !v.mwait));
            if (!v.mwait && !s_wr && s_rd) exp_read(v.exp_sel == 1, s_bc);
        end
        advance();
    endtask

    task automatic idle_reqs();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        m_if.waitrequest = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        idle_reqs();
        while (oq_id.size() > 0 && guard < 300) begin
            drive_ret($urandom);
            settle();
            advance();
            guard++;
        end
        checkw("drain_bound", 64'(oq_id.size()), 64'(0));
        settle();
        advance();
    endtask

    initial begin
        // arbitration: single writes, stalls, reads, burstcount 0
        vecs.push_back(mk(0,1,1, 0,1,1, 0, 0));
        vecs.push_back(mk(0,1,1, 0,1,1, 0, 1));
        vecs.push_back(mk(0,1,1, 0,1,1, 0, 0));
        vecs.push_back(mk(0,1,1, 0,1,1, 1, 1));
        vecs.push_back(mk(0,1,1, 0,1,1, 0, 1));
        vecs.push_back(mk(0,0,1, 0,1,1, 0, 1));
        vecs.push_back(mk(0,0,0, 0,1,1, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 2));
        vecs.push_back(mk(1,0,2, 0,1,1, 0, 0));
        vecs.push_back(mk(0,1,0, 1,0,1, 0, 1));
        vecs.push_back(mk(0,1,0, 0,0,0, 0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 3));
        // a0 write burst of 4 locks out a1's read, incl. stall and owner read
        vecs.push_back(mk(0,0,0, 0,1,1, 0, 1));
        vecs.push_back(mk(0,1,4, 1,0,1, 0, 0));
        vecs.push_back(mk(0,1,4, 1,0,1, 1, 0));
        vecs.push_back(mk(0,1,4, 1,0,1, 0, 0));
        vecs.push_back(mk(1,0,4, 1,0,1, 0, 2));
        vecs.push_back(mk(0,1,4, 1,0,1, 0, 0));
        vecs.push_back(mk(0,1,4, 1,0,1, 0, 0));
        vecs.push_back(mk(0,0,0, 1,0,1, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 3));
        // a0 read burst 2 then a1 read burst 3, returned back-to-back
        vecs.push_back(mk(1,0,2, 0,0,0, 0, 0));
        vecs.push_back(mk(0,0,0, 1,0,3, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 3));
`ifdef AVALON_MEM_ARB_STRICT_PRIO_EN
        vecs[1].exp_sel = 0;
        vecs[3].exp_sel = 0;
        vecs[4].exp_sel = 0;
        vecs[9].exp_sel = 0;
`endif

        a0_if.address = A0_ADDR; a0_if.byteenable = '1;
        a1_if.address = A1_ADDR; a1_if.byteenable = '1;
        m_if.readdata = '0; m_if.readdatavalid = 1'b0;
        idle_reqs();

        // reset state, with a0 already requesting
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b1, BW'(1), 32'h11);
        settle();
        check1("rst_a0_wait", a0_if.waitrequest, 1'b1);
        check1("rst_a1_wait", a1_if.waitrequest, 1'b1);
        check1("rst_m_write", m_if.write, 1'b0);
        check1("rst_m_read", m_if.read, 1'b0);
        check1("rst_rd_err", rd_err, 1'b0);
        checkw("rst_a0_rdata", 64'(a0_if.readdata), 64'(0));
        checkw("rst_a1_rdata", 64'(a1_if.readdata), 64'(0));
        advance();
        reset_n = 1'b1;
        idle_reqs();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].exp_sel == 3) drain();
            else apply_vec(vecs[i], i);
        end

        // fill the order FIFO (first read with burstcount 0)
        for (int i = 0; i < DEPTH; i++)
            apply_vec(mk(1,0,(i == 0) ? 0 : 1, 0,0,0, 0, 0), 100 + i);
        apply_vec(mk(1,0,1, 0,1,1, 0, 1), 200);
        apply_vec(mk(1,0,1, 1,0,1, 0, 2), 201);
        drive_ret(32'hC0DE_0001);
        apply_vec(mk(1,0,1, 0,0,0, 0, 0), 202);
        drain();

`ifdef AVALON_MEM_ARB_STRICT_PRIO_EN
        for (int i = 0; i < 6; i++)
            apply_vec(mk(0,1,1, 0,1,1, 0, 0), 300 + i);
`endif

        // reset in the middle of a write burst (beats_left = 2)
        apply_vec(mk(0,1,4, 0,0,0, 0, 0), 400);
        apply_vec(mk(0,1,4, 0,0,0, 0, 0), 401);
        set_req(1'b0, 1'b0, 1'b1, BW'(4), 32'h22);
        reset_n = 1'b0;
        settle();
        check1("mid_rst_m_write", m_if.write, 1'b0);
        check1("mid_rst_a0_wait", a0_if.waitrequest, 1'b1);
        check1("pre_rd_err", rd_err, 1'b0);
        advance();
        reset_n = 1'b1;
        idle_reqs();
        drive_ret(32'hDEAD_BEEF);
        apply_vec(mk(0,0,0, 0,1,1, 0, 1), 402);
        settle();
        check1("rd_err_set", rd_err, 1'b1);
        advance();
        settle();
        check1("rd_err_sticky", rd_err, 1'b1);
        advance();

        checkw("sb_empty", 64'(rq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
